// File: rtl/game_flow_controller.sv
// +--------------------------------------------------------------------------+
// | Module  : game_flow_controller                                           |
// | Purpose : Frame-rate game sequencer. It turns keycodes into single-shot  |
// |           key events and steps TITLE/READY/PLAY/PAUSE/OVER.              |
// | Option  : define GAME_FLOW_PAUSE_EN to build the PAUSE state and the     |
// |           KEY_PAUSE handling                                             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module game_flow_controller #(
    parameter logic [7:0] KEY_START    = 8'h2C,
    parameter logic [7:0] KEY_BACK     = 8'h05,
`ifdef GAME_FLOW_PAUSE_EN
    parameter logic [7:0] KEY_PAUSE    = 8'h13,
`endif
    parameter logic [7:0] READY_FRAMES = 8'd120,
    parameter logic [7:0] OVER_FRAMES  = 8'd180
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [1:0] life,
    output logic [2:0] game_state,
    output logic       run_en,
    output logic       load_level,
    output logic [7:0] countdown,
    output logic       start_evt,
    output logic       back_evt
);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_key_prev;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nx;
    logic       r_run_en;
    logic       r_load;
    logic       r_start;
    logic       r_back;
    logic       w_load_nx;
    logic       w_start_nx;
    logic       w_back_nx;
    logic       w_start_press;
    logic       w_back_press;

    // A press is the first frame a keycode shows up, so holding a key gives one event.
    assign w_start_press = (keycode == KEY_START) && (r_key_prev != KEY_START);
    assign w_back_press  = (keycode == KEY_BACK)  && (r_key_prev != KEY_BACK);

`ifdef GAME_FLOW_PAUSE_EN
    logic w_pause_press;
    assign w_pause_press = (keycode == KEY_PAUSE) && (r_key_prev != KEY_PAUSE);
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = 8'd0;
        w_load_nx  = 1'b0;
        w_start_nx = w_start_press;
        w_back_nx  = w_back_press;
        case (r_state)
            S_TITLE: begin
                if (w_start_press) begin
                    w_state_nx = S_READY;
                    w_load_nx  = 1'b1;
                    w_cnt_nx   = READY_FRAMES - 8'd1;
                end
            end
            S_READY: begin
                if (w_back_press) begin
                    w_state_nx = S_TITLE;
                end else if (r_cnt == 8'd0) begin
                    w_state_nx = S_PLAY;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            S_PLAY: begin
                // Losing the last life has priority over any key in the same frame.
                if (life == 2'd0) begin
                    w_state_nx = S_OVER;
                    w_cnt_nx   = OVER_FRAMES - 8'd1;
                end else if (w_back_press) begin
                    w_state_nx = S_TITLE;
`ifdef GAME_FLOW_PAUSE_EN
                end else if (w_pause_press) begin
                    w_state_nx = S_PAUSE;
`endif
                end
            end
`ifdef GAME_FLOW_PAUSE_EN
            S_PAUSE: begin
                if (w_back_press) begin
                    w_state_nx = S_TITLE;
                end else if (w_pause_press || w_start_press) begin
                    w_state_nx = S_PLAY;
                end
            end
`endif
            S_OVER: begin
                if (w_start_press) begin
                    w_state_nx = S_READY;
                    w_load_nx  = 1'b1;
                    w_cnt_nx   = READY_FRAMES - 8'd1;
                end else if (w_back_press || (r_cnt == 8'd0)) begin
                    w_state_nx = S_TITLE;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            default: begin
                // Unused encodings recover quietly to TITLE.
                w_state_nx = S_TITLE;
                w_start_nx = 1'b0;
                w_back_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state    <= S_TITLE;
            r_key_prev <= 8'h00;
            r_cnt      <= 8'd0;
            r_run_en   <= 1'b0;
            r_load     <= 1'b0;
            r_start    <= 1'b0;
            r_back     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_key_prev <= keycode;
            r_cnt      <= w_cnt_nx;
            r_run_en   <= (w_state_nx == S_PLAY);
            r_load     <= w_load_nx;
            r_start    <= w_start_nx;
            r_back     <= w_back_nx;
        end
    end

    assign game_state = r_state;
    assign countdown  = r_cnt;
    assign run_en     = r_run_en;
    assign load_level = r_load;
    assign start_evt  = r_start;
    assign back_evt   = r_back;

endmodule

`default_nettype wire

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer clocked once per video frame.
- Converts raw keyboard keycodes into single-shot key events and steps the game through TITLE, READY, PLAY, PAUSE and OVER.
- Drives the gating (run_en) and one-cycle control pulses consumed by the sprite/physics datapath, level loader and screen overlay mux.
- Replaces ad-hoc start/back pulse generation with one registered state machine.

Parameters:
- KEY_START, 8'h2C, keycode for "start/confirm" (space).
- KEY_BACK, 8'h05, keycode for "back to title" (B).
- KEY_PAUSE, 8'h13, keycode for pause toggle (P).
- READY_FRAMES, 8'd120, frames spent in READY countdown; legal 1..255.
- OVER_FRAMES, 8'd180, frames the game-over screen holds before auto-return; legal 1..255.

Ports:
- frame_clk  input  1  frame-rate clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- keycode  input  8  current keyboard keycode; 8'h00 = no key.
- life  input  2  remaining lives from the player datapath.
- game_state  output  3  current state: TITLE=0, READY=1, PLAY=2, PAUSE=3, OVER=4.
- run_en  output  1  high only while in PLAY; gates datapath motion.
- load_level  output  1  one-cycle pulse on every entry into READY from TITLE or OVER.
- countdown  output  8  frames remaining in READY or OVER; 0 in other states.
- start_evt  output  1  one-cycle pulse when a KEY_START press is detected, whatever the state.
- back_evt  output  1  one-cycle pulse when a KEY_BACK press is detected, whatever the state.

Behaviour:
- Reset, sampled on frame_clk rising edge:
  - game_state=TITLE, countdown=0.
  - run_en=0, load_level=0, start_evt=0, back_evt=0.
  - key_prev=8'h00.
- key_prev register captures keycode every cycle.
- Press of key K: keycode==K && key_prev!=K.
  - A held key yields exactly one event.
  - Release then re-press yields a new event.
  - A direct change from one key to another counts as a press of the new key.
- All outputs registered. The state and outputs seen after edge N reflect keycode, life and state before edge N, i.e. 1-cycle latency.
- Pulses (load_level, start_evt, back_evt) are high for exactly one cycle per event.
- Transitions (evaluated in priority order within each state):
  - TITLE:
    - start -> READY; load_level=1; countdown=READY_FRAMES-1.
    - back and pause are ignored.
  - READY:
    - back -> TITLE.
    - else if countdown==0 -> PLAY.
    - else countdown-1.
  - PLAY:
    - life==0 -> OVER; countdown=OVER_FRAMES-1. This beats every key in the same cycle.
    - else back -> TITLE.
    - else pause -> PAUSE.
    - start is ignored.
  - PAUSE:
    - back -> TITLE.
    - else pause or start -> PLAY.
    - life is not checked.
  - OVER:
    - start -> READY; load_level=1; countdown=READY_FRAMES-1. Start beats timeout.
    - else back -> TITLE.
    - else if countdown==0 -> TITLE.
    - else countdown-1.
- countdown is forced to 0 whenever the next state is TITLE, PLAY or PAUSE.
- run_en = (next state == PLAY), registered with game_state.
- Illegal game_state encodings (5..7) -> TITLE on the next edge, with all pulses 0.
- Reset mid-countdown or mid-PLAY:
  - Returns to TITLE within one edge.
  - Pending pulses are dropped.
  - key_prev is cleared, so a key held through reset produces a press event on the first post-reset cycle.

Optional Feature:
- Macro: GAME_FLOW_PAUSE_EN.
- Defined: KEY_PAUSE handling and the PAUSE state exist as specified above.
- Undefined:
  - KEY_PAUSE is ignored in every state.
  - PAUSE is unreachable; encoding 3 is treated as illegal and recovers to TITLE.
  - No pause-detection logic is synthesised.

Test Plan:
- Reset; hold keycode=8'h2C for 5 frames.
  - Exactly one start_evt and one load_level pulse, on the first edge.
  - game_state=1 with countdown=119, decrementing by 1 per frame.
  - After 120 frames in READY, game_state=2 and run_en=1.
- In PLAY, drive keycode=8'h13 then 8'h00 then 8'h13 (macro defined).
  - game_state 2 -> 3 -> 3 -> 2; run_en 1 -> 0 -> 0 -> 1.
  - With the macro undefined, game_state stays 2 throughout.
- In PLAY, drive life=0 and keycode=8'h05 in the same cycle.
  - game_state=4, countdown=179.
  - back_evt pulses once, but the state does not go to TITLE.
- In OVER, hold keycode=8'h00 for 180 frames.
  - countdown reaches 0, then game_state=0 on the next edge.
- In OVER with countdown=50, press 8'h2C.
  - game_state=1, load_level=1 for one cycle, countdown=119.
- Assert Reset in READY with countdown=60 while 8'h2C is held.
  - Next edge: game_state=0, countdown=0, all pulses 0.
  - First post-reset edge: start_evt=1, load_level=1, game_state=1.
